sram_line_en_wb_master_bridge: RTL and testbench

Bridge that presents a generic line-enable SRAM responder port to a local client and turns each access into a single Wishbone classic master cycle. It is the counterpart of our Wishbone-slave-to-SRAM bridges: an SRAM-style client (a CPU scratch port or DMA engine) can reach any Wishbone slave through it. Writes are posted through a small FIFO. Reads stall the client via `busy` until the Wishbone ACK returns.

---
 rtl/sram_line_en_wb_master_bridge_if.sv | 27 ++
 rtl/sram_line_en_wb_master_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_sram_line_en_wb_master_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_line_en_wb_master_bridge_if.sv
// Wishbone classic bus bundle used by sram_line_en_wb_master_bridge.
// The bridge connects through the master modport and a Wishbone slave
// connects through the slave modport.
interface sram_line_en_wb_master_bridge_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
);
  logic                      CYC;
  logic                      STB;
  logic                      WE;
  logic [ADDRESS_WIDTH+1:0]  ADR;
  logic [DATA_WIDTH/8-1:0]   SEL;
  logic [DATA_WIDTH-1:0]     DAT_W;
  logic [DATA_WIDTH-1:0]     DAT_R;
  logic                      ACK;
  logic                      ERR;

  modport master (
    output CYC, STB, WE, ADR, SEL, DAT_W,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  CYC, STB, WE, ADR, SEL, DAT_W,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/sram_line_en_wb_master_bridge.sv
// sram_line_en_wb_master_bridge
// Presents a line-enable SRAM responder port to a local client and turns each
// access into one Wishbone classic master cycle. Writes are posted through a
// small FIFO; reads hold the client off with busy until ACK/ERR returns.
// Optional build macro SRAM_WB_MASTER_TIMEOUT_EN adds a watchdog that ends a
// cycle as a bus error after TIMEOUT_CYCLES cycles without a termination.
module sram_line_en_wb_master_bridge #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int WFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     read_en,
  input  logic                     write_en,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr,
  sram_line_en_wb_master_bridge_if.master wb
);

  localparam int PW = $clog2(WFIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [1:0]               state_reg, state_next;
  logic [PW:0]              wptr_reg, rptr_reg, wptr_next, rptr_next;
  logic [ADDRESS_WIDTH-1:0] fifo_addr_mem [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_mem [WFIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;

  logic                     pend_reg, pend_next;
  logic [ADDRESS_WIDTH-1:0] pend_addr_reg;

  logic                     cyc_reg, cyc_next;
  logic                     we_reg, we_next;
  logic [ADDRESS_WIDTH+1:0] adr_reg, adr_next;
  logic [DATA_WIDTH-1:0]    dat_w_reg, dat_w_next;

  logic [DATA_WIDTH-1:0]    read_data_reg;
  logic                     read_valid_reg;
  logic                     busy_reg;
  logic                     err_reg;

  logic accept, push, rd_accept, fifo_empty, full_next;
  logic term, term_err, pop, rd_done, timeout;

  // Client handshake: nothing is accepted while busy; a simultaneous
  // read+write keeps the write and drops the read.
  assign accept    = !busy_reg;
  assign push      = accept && write_en;
  assign rd_accept = accept && read_en && !write_en;

  assign fifo_empty = (wptr_reg == rptr_reg);
  assign head_addr  = fifo_addr_mem[rptr_reg[PW-1:0]];
  assign head_data  = fifo_data_mem[rptr_reg[PW-1:0]];

  // A watchdog expiry terminates exactly like a slave ERR.
  assign term_err = wb.ERR || timeout;
  assign term     = (state_reg != ST_IDLE) && (wb.ACK || term_err);
  assign pop      = term && (state_reg == ST_WR);
  assign rd_done  = term && (state_reg == ST_RD);

  assign wptr_next = wptr_reg + {{PW{1'b0}}, push};
  assign rptr_next = rptr_reg + {{PW{1'b0}}, pop};
  assign full_next = (wptr_next[PW] != rptr_next[PW]) &&
                     (wptr_next[PW-1:0] == rptr_next[PW-1:0]);

  assign pend_next = rd_done ? 1'b0 : (rd_accept ? 1'b1 : pend_reg);

`ifdef SRAM_WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;

  assign timeout = (state_reg != ST_IDLE) && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES));

  // Watchdog counts bus-cycle length; IDLE between cycles restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      tmo_cnt_reg <= '0;
    end else if (!timeout) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  // Posted-write storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wptr_reg[PW-1:0]] <= addr;
      fifo_data_mem[wptr_reg[PW-1:0]] <= write_data;
    end
  end

  // Bus sequencer: queued writes go first so program order is kept, and an
  // incoming request can start its cycle on the very edge it is accepted.
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    we_next    = we_reg;
    adr_next   = adr_reg;
    dat_w_next = dat_w_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_WR;
          cyc_next   = 1'b1;
          we_next    = 1'b1;
          adr_next   = {head_addr, 2'b00};
          dat_w_next = head_data;
        end else if (push) begin
          state_next = ST_WR;
          cyc_next   = 1'b1;
          we_next    = 1'b1;
          adr_next   = {addr, 2'b00};
          dat_w_next = write_data;
        end else if (pend_reg) begin
          state_next = ST_RD;
          cyc_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = {pend_addr_reg, 2'b00};
        end else if (rd_accept) begin
          state_next = ST_RD;
          cyc_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = {addr, 2'b00};
        end
      end
      ST_WR, ST_RD: begin
        if (term) begin
          state_next = ST_IDLE;
          cyc_next   = 1'b0;
          we_next    = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cyc_next   = 1'b0;
        we_next    = 1'b0;
      end
    endcase
  end

  // State, pointers, bus and client registers; reset drops CYC immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      pend_reg       <= 1'b0;
      pend_addr_reg  <= '0;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      adr_reg        <= '0;
      dat_w_reg      <= '0;
      read_data_reg  <= '0;
      read_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wptr_reg       <= wptr_next;
      rptr_reg       <= rptr_next;
      pend_reg       <= pend_next;
      cyc_reg        <= cyc_next;
      we_reg         <= we_next;
      adr_reg        <= adr_next;
      dat_w_reg      <= dat_w_next;
      busy_reg       <= full_next || pend_next;
      read_valid_reg <= rd_done;
      if (rd_accept) begin
        pend_addr_reg <= addr;
      end
      if (rd_done) begin
        read_data_reg <= term_err ? '0 : wb.DAT_R;
      end
      if (term && term_err) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign wb.CYC   = cyc_reg;
  assign wb.STB   = cyc_reg;
  assign wb.WE    = we_reg;
  assign wb.ADR   = adr_reg;
  assign wb.SEL   = {(DATA_WIDTH/8){cyc_reg}};
  assign wb.DAT_W = dat_w_reg;

  assign read_data  = read_data_reg;
  assign read_valid = read_valid_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_sram_line_en_wb_master_bridge.sv
// Testbench for sram_line_en_wb_master_bridge: RAM-backed Wishbone slave with
// configurable wait states, ERR address and a never-ack mode; table-driven
// client traffic plus hand-written sequences for the multi-cycle corners.
module tb_sram_line_en_wb_master_bridge;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] addr;
  logic          read_en, write_en, err_clr;
  logic [DW-1:0] write_data, read_data;
  logic          read_valid, busy, err;

  always #5 clk = ~clk;

  sram_line_en_wb_master_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_line_en_wb_master_bridge #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WFIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .busy(busy), .err(err), .err_clr(err_clr), .wb(bus)
  );

  // ---------------- Wishbone slave model ----------------
  bit [31:0]   ram [1024];
  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  bit          err_en = 1'b0;
  logic [11:0] err_adr = 12'hFFC;
  int          wcnt;
  bit          log_we [$];
  logic [11:0] log_adr [$];
  bit          log_err [$];

  assign bus.ACK   = bus.CYC && bus.STB && !no_ack && (wcnt >= ack_delay);
  assign bus.ERR   = bus.CYC && bus.STB && err_en && (bus.ADR == err_adr);
  assign bus.DAT_R = ram[bus.ADR[11:2]];

  always_ff @(posedge clk) begin
    if (!bus.CYC || bus.ACK || bus.ERR) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (bus.CYC && bus.STB && (bus.ACK || bus.ERR)) begin
      if (bus.WE && !bus.ERR) ram[bus.ADR[11:2]] <= bus.DAT_W;
      log_we.push_back(bus.WE);
      log_adr.push_back(bus.ADR);
      log_err.push_back(bus.ERR);
      $display("bus %s adr=0x%03h dat=0x%08h term=%s", bus.WE ? "WR" : "RD", bus.ADR,
               bus.WE ? bus.DAT_W : bus.DAT_R, bus.ERR ? "err" : "ack");
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_ctl"}, {26'd0, bus.CYC, bus.STB, bus.WE, read_valid, busy, err}, 32'd0);
    chk({p, "_adr"}, {20'd0, bus.ADR}, 32'd0);
    chk({p, "_sel"}, {28'd0, bus.SEL}, 32'd0);
    chk({p, "_datw"}, bus.DAT_W, 32'd0);
    chk({p, "_rdata"}, read_data, 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    addr = a; write_data = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    $display("client write addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    bit early = 1'b0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    addr = a; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    n = 0;
    while (!read_valid && n < 200) begin
      if (!busy) early = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("rd_valid_seen", {31'd0, read_valid}, 32'd1);
    chk("rd_busy_held", {31'd0, early}, 32'd0);
    chk("rd_busy_low_at_pulse", {31'd0, busy}, 32'd0);
    d = read_data;
    $display("client read addr=0x%03h data=0x%08h err=%0d", a, d, err);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } vec_t;

  vec_t          vecs [13];
  logic [DW-1:0] d;
  int            base;
  int            n;
  bit            flag;
  logic [11:0]   exp_order [4];
  logic [11:0]   exp_full [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    addr = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0; err_clr = 1'b0;

    vecs[0]  = '{1'b1, 10'h001, 32'h1111_1111};
    vecs[1]  = '{1'b1, 10'h002, 32'h2222_2222};
    vecs[2]  = '{1'b1, 10'h003, 32'h3333_3333};
    vecs[3]  = '{1'b0, 10'h002, 32'h2222_2222};
    vecs[4]  = '{1'b0, 10'h001, 32'h1111_1111};
    vecs[5]  = '{1'b1, 10'h3FE, 32'hA5A5_A5A5};
    vecs[6]  = '{1'b0, 10'h3FE, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 10'h000, 32'h0000_0000};
    vecs[8]  = '{1'b1, 10'h000, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 10'h000, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 10'h002, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 10'h002, 32'hCAFE_F00D};
    vecs[12] = '{1'b0, 10'h003, 32'h3333_3333};
    exp_order = '{12'h004, 12'h008, 12'h00C, 12'h008};
    exp_full  = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h110};

    // Reset state
    repeat (2) @(negedge clk);
    chk_rst("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Single write: one WE cycle starting the cycle after acceptance
    addr = 10'h005; write_data = 32'hDEAD_BEEF; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    chk("wr_ctl", {29'd0, bus.CYC, bus.STB, bus.WE}, 32'd7);
    chk("wr_adr", {20'd0, bus.ADR}, 32'h014);
    chk("wr_sel", {28'd0, bus.SEL}, 32'hF);
    chk("wr_datw", bus.DAT_W, 32'hDEAD_BEEF);
    chk("wr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("wr_cyc_fall", {31'd0, bus.CYC}, 32'd0);
    chk("wr_slave_ram", ram[5], 32'hDEAD_BEEF);

    // Read latency with a zero-wait slave
    addr = 10'h005; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    chk("rd_t1_ctl", {28'd0, busy, bus.CYC, bus.STB, bus.WE}, 32'b1110);
    chk("rd_t1_adr", {20'd0, bus.ADR}, 32'h014);
    @(negedge clk);
    chk("rd_t2_ctl", {29'd0, read_valid, busy, bus.CYC}, 32'b100);
    chk("rd_t2_data", read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_t3_pulse_end", {31'd0, read_valid}, 32'd0);
    chk("rd_t3_data_held", read_data, 32'hDEAD_BEEF);

    // Table-driven client traffic against the RAM slave
    base = log_adr.size();
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].a, vecs[i].d);
      end else begin
        do_read(vecs[i].a, d);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].d);
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d_adr", k), {20'd0, log_adr[base + k]}, {20'd0, exp_order[k]});
      chk($sformatf("order%0d_we", k), {31'd0, log_we[base + k]}, (k < 3) ? 32'd1 : 32'd0);
    end

    // FIFO full with a slow slave
    ack_delay = 10;
    base = log_adr.size();
    for (int i = 0; i < 4; i++) begin
      do_write(10'h040 + 10'(i), 32'h0000_00F0 + 32'(i));
      if (i == 2) chk("full_busy_after3", {31'd0, busy}, 32'd0);
    end
    chk("full_busy_after4", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("full_busy_falls", {31'd0, busy}, 32'd0);
    chk("full_held_until_ack", 32'(log_adr.size() - base), 32'd1);
    do_write(10'h044, 32'h0000_00F4);
    n = 0;
    while ((log_adr.size() - base) < 5 && n < 300) begin @(negedge clk); n++; end
    chk("full_drain_count", 32'(log_adr.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("full%0d_adr", k), {20'd0, log_adr[base + k]}, {20'd0, exp_full[k]});
      chk($sformatf("full%0d_we", k), {31'd0, log_we[base + k]}, 32'd1);
    end
    chk("full_ram_last", ram[10'h044], 32'h0000_00F4);
    ack_delay = 0;
    @(negedge clk);

    // Read error: ERR beats the simultaneous ACK, data forced to 0
    err_en = 1'b1;
    do_read(10'h3FF, d);
    chk("err_rdata", d, 32'd0);
    chk("err_flag", {31'd0, err}, 32'd1);
    chk("err_bus_term", {31'd0, log_err[log_err.size() - 1]}, 32'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);
    // err_clr held across a new ERR: set wins on that edge
    err_clr = 1'b1;
    do_read(10'h3FF, d);
    chk("err_set_wins", {31'd0, err}, 32'd1);
    @(negedge clk);
    chk("err_clr_held", {31'd0, err}, 32'd0);
    err_clr = 1'b0;
    err_en = 1'b0;

    // Slave that never acknowledges
    no_ack = 1'b1;
    addr = 10'h020; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
    n = 0;
    while (bus.CYC && n < 50) begin n++; @(negedge clk); end
    chk("tmo_cyc_cycles", 32'(n), 32'd9);
    chk("tmo_rv", {31'd0, read_valid}, 32'd1);
    chk("tmo_rdata", read_data, 32'd0);
    chk("tmo_err", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    addr = 10'h021; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_cyc", {31'd0, bus.CYC}, 32'd1);
`else
    repeat (30) @(negedge clk);
    chk("notmo_cyc", {31'd0, bus.CYC}, 32'd1);
    chk("notmo_busy", {31'd0, busy}, 32'd1);
`endif

    // Reset mid-cycle: outputs clear without waiting for a clock edge
    rstn = 1'b0;
    #1;
    chk_rst("midrst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    no_ack = 1'b0;
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.CYC || read_valid) flag = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, flag}, 32'd0);
    chk("post_rst_busy_err", {30'd0, busy, err}, 32'd0);
    do_write(10'h007, 32'h7777_0007);
    do_read(10'h007, d);
    chk("post_rst_rdata", d, 32'h7777_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
